// File: rtl/mem_responder_if.sv
// Load/store port between the core's control matrix and the memory responder.
interface mem_responder_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  mrd_i;
  logic                  mwr_i;
  logic [2:0]            funct3_i;
  logic [DATA_WIDTH-1:0] byte_addr_i;
  logic [DATA_WIDTH-1:0] wd_i;
  logic [DATA_WIDTH-1:0] rd_o;
  logic                  busy_o;
  logic                  rdy_o;
  logic                  fault_o;

  modport master (
    output mrd_i, mwr_i, funct3_i, byte_addr_i, wd_i,
    input  rd_o, busy_o, rdy_o, fault_o
  );

  modport slave (
    input  mrd_i, mwr_i, funct3_i, byte_addr_i, wd_i,
    output rd_o, busy_o, rdy_o, fault_o
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: one sized load/store at a time with wait states, read-modify-write
// for sub-word stores and sign/zero-extended lane-aligned loads.
module mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WORDS       = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic            clk_i,
  input  logic            reset_i,
  mem_responder_if.slave  bus
);
  localparam int unsigned           IdxW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0]            WaitLast  = 4'(WAIT_STATES);
  localparam logic [DATA_WIDTH-3:0] WordLimit = (DATA_WIDTH-2)'(WORDS);

  typedef enum logic [2:0] {StIdle, StWait, StAccess, StMerge, StDone} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic                  wr_q;
  logic                  fault_pend_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic                  accept;
  logic                  type_bad, misaligned, out_of_range, req_fault;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [DATA_WIDTH-1:0] load_val, merged;

  assign accept = (state_q == StIdle) && (bus.mrd_i || bus.mwr_i);

  // Fault check is evaluated on the live inputs and captured with the request.
  always_comb begin
    type_bad   = 1'b0;
    misaligned = 1'b0;
    if (bus.mrd_i && bus.mwr_i) begin
      type_bad = 1'b1;
    end else if (bus.mwr_i) begin
      type_bad = bus.funct3_i[2] || (bus.funct3_i == 3'b011);
    end else begin
      type_bad = bus.funct3_i inside {3'b011, 3'b110, 3'b111};
    end
    case (bus.funct3_i[1:0])
      2'b01:   misaligned = bus.byte_addr_i[0];
      2'b10:   misaligned = |bus.byte_addr_i[1:0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = bus.byte_addr_i[DATA_WIDTH-1:2] >= WordLimit;
    req_fault    = type_bad || misaligned || out_of_range;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = 4'd1;
          state_d = (WAIT_STATES == 0) ? StAccess : StWait;
        end
      end
      StWait: begin
        if (cnt_q == WaitLast) state_d = StAccess;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      StAccess: state_d = StMerge;
      StMerge:  state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    lane_b   = rdata_q[{off_q, 3'b000} +: 8];
    lane_h   = rdata_q[{off_q[1], 4'b0000} +: 16];
    load_val = rdata_q;
    case (funct3_q)
      3'b000:  load_val = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      3'b001:  load_val = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      3'b100:  load_val = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      3'b101:  load_val = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      default: load_val = rdata_q;
    endcase
    merged = rdata_q;
    case (funct3_q[1:0])
      2'b00:   merged[{off_q, 3'b000} +: 8]    = wd_q[7:0];
      2'b01:   merged[{off_q[1], 4'b0000} +: 16] = wd_q[15:0];
      default: merged = wd_q;
    endcase
  end

  // Datapath and RAM carry no reset; RAM contents survive reset by design.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      funct3_q     <= bus.funct3_i;
      off_q        <= bus.byte_addr_i[1:0];
      idx_q        <= bus.byte_addr_i[IdxW+1:2];
      wd_q         <= bus.wd_i;
      wr_q         <= bus.mwr_i;
      fault_pend_q <= req_fault;
    end
    if (state_q == StAccess) begin
      rdata_q <= mem[idx_q];
    end
    if ((state_q == StMerge) && wr_q && !fault_pend_q && !reset_i) begin
      mem[idx_q] <= merged;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StMerge) begin
        fault_q <= fault_pend_q;
        if (!wr_q && !fault_pend_q) rd_q <= load_val;
      end
    end
  end

  assign bus.rd_o    = rd_q;
  assign bus.busy_o  = (state_q != StIdle);
  assign bus.rdy_o   = (state_q == StDone);
  assign bus.fault_o = fault_q;
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle core's load/store port. It accepts one byte-addressed read or write request at a time, sized by the instruction's funct3, and stalls the core through `busy_o` for a parameterised number of wait states. Sub-word stores are performed as read-modify-write on an internal word RAM, and loads are lane-aligned and sign- or zero-extended. It sits where the core's address mux, write-data register and control matrix meet memory, and feeds `busy_o` into the control matrix's memory-busy input.

## Interface
- `DATA_WIDTH`, 32: data and address width.
- `WORDS`, 1024: internal RAM depth in 32-bit words.
- `WAIT_STATES`, 2: extra cycles inserted before the RAM access (0..15).

- `clk_i`  in  1  single clock; all state changes on the rising edge.
- `reset_i`  in  1  reset, synchronous and active-high.
- `mrd_i`  in  1  read request strobe.
- `mwr_i`  in  1  write request strobe.
- `funct3_i`  in  3  access size and signedness (RV32I load/store funct3).
- `byte_addr_i`  in  DATA_WIDTH  byte address.
- `wd_i`  in  DATA_WIDTH  store data; the lane to store is in the low bits.
- `rd_o`  out  DATA_WIDTH  formatted load data, registered.
- `busy_o`  out  1  request in progress; high in every state except IDLE.
- `rdy_o`  out  1  one-cycle completion pulse.
- `fault_o`  out  1  completion status; high when the completed request was rejected.

## Operation
- **States and transitions**
  - IDLE → WAIT, or → ACCESS if `WAIT_STATES`=0.
  - WAIT → ACCESS once the counter reaches `WAIT_STATES`.
  - ACCESS → MERGE → DONE → IDLE.
- **Accept (IDLE only)**
  - A request is accepted when `mrd_i` or `mwr_i` is high.
  - On accept, the block captures `funct3_i`, `byte_addr_i`, `wd_i`, the request type and the fault check.
  - Inputs are don't-care after the accept cycle.
  - Strobes seen outside IDLE are ignored and are not queued.
- **Fault conditions** (any one rejects the request):
  - `mrd_i` and `mwr_i` high together.
  - Reserved funct3: loads 011/110/111; stores 011 and 1xx.
  - Misaligned halfword access: addr[0]≠0.
  - Misaligned word access: addr[1:0]≠0.
  - Word index addr[31:2] ≥ `WORDS`.
- **Faulted requests**
  - Still walk the full state sequence, so latency is identical to a normal request.
  - The RAM is never written.
  - `rd_o` is left unchanged.
  - `fault_o`=1 at DONE.
- **ACCESS:** synchronous RAM read of the word at index addr[31:2], for both reads and writes.
- **MERGE, read**
  - Select lane by addr[1:0] (LB/LBU) or addr[1] (LH/LHU); little-endian lanes.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - Register the result into `rd_o`.
- **MERGE, write**
  - SW writes `wd_i` whole.
  - SB replaces byte lane addr[1:0] with `wd_i`[7:0].
  - SH replaces half lane addr[1] with `wd_i`[15:0].
  - The merged word is written to the RAM in this cycle.
- **DONE:** `rdy_o`=1; `fault_o` is updated.
- **Held outputs:** `rd_o` holds until the next successful read completes. `fault_o` holds until the next completion.

## Timing
- **Reset**
  - State returns to IDLE and the wait counter clears.
  - Outputs: `rd_o`=0, `busy_o`=0, `rdy_o`=0, `fault_o`=0.
  - RAM contents are not cleared.
- **Reset mid-operation**
  - The request is aborted with no `rdy_o` pulse.
  - Reset asserted in the MERGE cycle suppresses the RAM write; reset has priority.
- **Latency**
  - Accept at edge T; `busy_o` is high from T+1.
  - `rdy_o` is high in cycle T+`WAIT_STATES`+3.
  - `busy_o` falls the cycle after `rdy_o`.
- **Throughput:** at most one request per `WAIT_STATES`+4 cycles. A new request may be accepted in the first IDLE cycle after DONE.
- **`rd_o` valid:** `rd_o` is valid in the `rdy_o` cycle and thereafter.
- **Request held high:** a core that keeps `mrd_i` high through DONE gets a second access. The control matrix must drop strobes once `busy_o` is seen.
- **Width rules:** RAM index uses addr bits [log2(`WORDS`)+1:2]. The range check uses the full addr[31:2].

## Test plan
- **Full-word write/read:** with `WAIT_STATES`=2, SW 0xDEADBEEF to 0x40, then LW 0x40.
  - `rdy_o` arrives exactly 5 cycles after each accept.
  - `rd_o`=0xDEADBEEF; `fault_o`=0.
  - `busy_o` is high for 5 cycles per request.
- **Byte stores and sign handling:** SB 0x80 to 0x41, then SB 0x7F to 0x43.
  - LW 0x40 → 0x7FAD80EF.
  - LB 0x41 → 0xFFFFFF80.
  - LBU 0x41 → 0x00000080.
  - LB 0x43 → 0x0000007F.
- **Halfword lanes:** SH 0x8001 to 0x42.
  - LH 0x42 → 0xFFFF8001.
  - LHU 0x42 → 0x00008001.
  - LW 0x40 → 0x80018 0EF, i.e. 0x800180EF when the lower half holds 0x80EF from the previous scenario.
- **Fault cases:** each of the following gives `fault_o`=1 at `rdy_o` with normal latency, and leaves the RAM and `rd_o` unchanged.
  - LW 0x42 (misaligned).
  - SH 0x41 (misaligned).
  - funct3 011 (reserved).
  - `mrd_i`+`mwr_i` together.
  - LW at 0x1000 with `WORDS`=1024 (out of range).
- **Reset mid-operation:** SW 0x12345678 to 0x44 with reset asserted in the MERGE cycle.
  - No `rdy_o` pulse.
  - All outputs are 0 the next cycle.
  - A later LW 0x44 returns the old contents.
- **Zero wait states and back-to-back:** with `WAIT_STATES`=0, hold `mrd_i` high continuously.
  - `rdy_o` arrives 3 cycles after accept.
  - Re-accept happens on the cycle after DONE.
  - Strobes during WAIT/ACCESS/MERGE produce no extra accesses.
